// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit line among NUM_REQ requesters.
// Frames are 1 start, MESSAGE_SIZE data bits LSB-first, 1 stop, then GAP_BITS idle bit times.
module uart_tx_scheduler #(
    parameter int clk_freq     = 100_000_000,
    parameter int baud_rate    = 38400,
    parameter int NUM_REQ      = 4,
    parameter int GAP_BITS     = 1,
    parameter int MESSAGE_SIZE = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*MESSAGE_SIZE-1:0] msg,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            done,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            TxD
);

    localparam int BIT_CYCLES = clk_freq / baud_rate;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (MESSAGE_SIZE > 1) ? $clog2(MESSAGE_SIZE) : 1;
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(MESSAGE_SIZE - 1);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           baud_cnt_q, baud_cnt_d;
    logic [IW-1:0]           bit_idx_q, bit_idx_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic [MESSAGE_SIZE-1:0] shreg_q, shreg_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]           grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    done_q, done_d;
    logic                    txd_q, txd_d;

    logic                    win_found;
    logic [PW-1:0]           win_idx;
    logic [PW-1:0]           cand;
    logic                    baud_last;
    int                      idx;

    // Round-robin search starting at rr_ptr_q; first requester with req high wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            cand = PW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end else begin
                win_found = win_found;
            end
        end
    end

    // Frame sequencer: next-state, counters, shift register and output pulses.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        gap_cnt_d  = gap_cnt_q;
        shreg_d    = shreg_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        txd_d      = txd_q;
        done_d     = 1'b0;
        baud_last  = (baud_cnt_q == BAUD_LAST);

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (win_found) begin
                    ack_d      = NUM_REQ'(1) << win_idx;
                    grant_id_d = win_idx;
                    shreg_d    = msg[win_idx*MESSAGE_SIZE +: MESSAGE_SIZE];
                    rr_ptr_d   = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                    state_d    = S_START;
                    txd_d      = 1'b0;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    gap_cnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d    = S_DATA;
                    baud_cnt_d = '0;
                    txd_d      = shreg_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + IW'(1);
                        txd_d     = shreg_d[0];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (GAP_BITS == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // done is registered, so it is raised when the upcoming cycle is the frame's last.
        if (baud_cnt_d == BAUD_LAST &&
            ((state_d == S_STOP && GAP_BITS == 0) ||
             (state_d == S_GAP && gap_cnt_d == GAP_LAST))) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            gap_cnt_q  <= '0;
            shreg_q    <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            done_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            shreg_q    <= shreg_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            txd_q      <= txd_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != S_IDLE);
    assign TxD      = txd_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with BIT_CYCLES=16, four requesters, 8-bit messages, 1 gap bit.
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int MS = 8;
    localparam int BC = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*MS-1:0] msg;
    logic [NR-1:0] ack;
    logic          done;
    logic [1:0]    grant_id;
    logic          busy;
    logic          txd;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_scheduler #(
        .clk_freq(16), .baud_rate(1), .NUM_REQ(NR), .GAP_BITS(1), .MESSAGE_SIZE(MS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .msg(msg), .ack(ack), .done(done),
        .grant_id(grant_id), .busy(busy), .TxD(txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         off;
        logic       txd;
        logic       busy;
        logic       done;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int cycles, output logic [3:0] a);
        cycles = 0;
        a = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (ack != 4'b0000) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick();
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int         cyc;
    int         off;
    logic [3:0] a;
    logic [7:0] cap;
    logic       ack1_seen;

    initial begin
        // Single-request checkpoints relative to the ack edge; A5 goes out LSB first.
        tbl[0]  = '{0,   1'b0, 1'b1, 1'b0, 4'b0100};
        tbl[1]  = '{15,  1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[2]  = '{16,  1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[3]  = '{31,  1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[4]  = '{32,  1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[5]  = '{48,  1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[6]  = '{64,  1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[7]  = '{80,  1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[8]  = '{96,  1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[9]  = '{112, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[10] = '{127, 1'b0, 1'b1, 1'b0, 4'b0000};
        tbl[11] = '{128, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[12] = '{144, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[13] = '{160, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[14] = '{174, 1'b1, 1'b1, 1'b0, 4'b0000};
        tbl[15] = '{175, 1'b1, 1'b1, 1'b1, 4'b0000};
        tbl[16] = '{176, 1'b1, 1'b0, 1'b0, 4'b0000};

        msg = '0;
        do_reset();
        chk("rst_txd",   32'(txd),      32'd1);
        chk("rst_ack",   32'(ack),      32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);

        // Single request from requester 2.
        for (int i = 0; i < 8; i++) tick();
        msg[2*MS +: MS] = 8'hA5;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        off = 0;
        chk("single_grant", 32'(grant_id), 32'd2);
        for (int i = 0; i < 17; i++) begin
            while (off < tbl[i].off) begin
                tick();
                off++;
            end
            chk($sformatf("single_txd@%0d", tbl[i].off),  32'(txd),  32'(tbl[i].txd));
            chk($sformatf("single_busy@%0d", tbl[i].off), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("single_done@%0d", tbl[i].off), 32'(done), 32'(tbl[i].done));
            chk($sformatf("single_ack@%0d", tbl[i].off),  32'(ack),  32'(tbl[i].ack));
        end

        // Round-robin with all four requests held.
        do_reset();
        msg = 32'h44332211;
        req = 4'b1111;
        tick();
        chk("rr_first_ack", 32'(ack), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            wait_ack(400, cyc, a);
            chk($sformatf("rr_ack_%0d", i), 32'(a), 32'(4'b0001 << (i % 4)));
            chk($sformatf("rr_gap_%0d", i), 32'(cyc), 32'd177);
        end

        // Fairness: req3 raised during requester 0's frame wins over req0.
        do_reset();
        req = 4'b0001;
        tick();
        chk("fair_ack0", 32'(ack), 32'h1);
        for (int i = 0; i < 20; i++) tick();
        req = 4'b1001;
        wait_ack(400, cyc, a);
        chk("fair_ack3", 32'(a), 32'h8);
        req = 4'b0001;
        wait_ack(400, cyc, a);
        chk("fair_ack0_again", 32'(a), 32'h1);

        // Withdraw: req1 pulsed only while busy is never granted.
        req = 4'b0000;
        ack1_seen = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            ack1_seen = ack1_seen | ack[1];
        end
        req = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            tick();
            ack1_seen = ack1_seen | ack[1];
        end
        chk("withdraw_no_ack1", 32'(ack1_seen), 32'd0);
        chk("withdraw_txd",     32'(txd),       32'd1);
        chk("withdraw_busy",    32'(busy),      32'd0);

        // Mid-frame msg change must not affect the latched byte.
        msg[0 +: MS] = 8'h3C;
        req = 4'b0001;
        tick();
        chk("msgchg_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        off = 0;
        cap = '0;
        while (off < 20) begin
            tick();
            off++;
        end
        msg[0 +: MS] = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            while (off < 16*k + 8) begin
                tick();
                off++;
            end
            cap[k-1] = txd;
        end
        chk("msgchg_byte", 32'(cap), 32'h3C);
        wait_idle("msgchg_idle");

        // Reset during DATA bit 3 truncates the frame and restores priority to requester 0.
        msg[2*MS +: MS] = 8'h00;
        req = 4'b0100;
        tick();
        chk("rstmid_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        off = 0;
        while (off < 70) begin
            tick();
            off++;
        end
        chk("rstmid_pre_txd", 32'(txd), 32'd0);
        rst = 1'b1;
        tick();
        chk("rstmid_txd",   32'(txd),      32'd1);
        chk("rstmid_busy",  32'(busy),     32'd0);
        chk("rstmid_grant", 32'(grant_id), 32'd0);
        chk("rstmid_done",  32'(done),     32'd0);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        chk("rstmid_next_ack",   32'(ack),      32'h2);
        chk("rstmid_next_grant", 32'(grant_id), 32'd1);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
